// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the rate-1/2 convolutional encoder and its matching
// Viterbi decoder: the encoder state encoding and the default code parameters.
// The decoder derives its trellis state width and output bit count from the
// same constants, so both ends of the link agree on the code.
//
// Configuration macro used by files importing this package: ENC_TAIL_EN
// (see conv_encoder.sv).
// -----------------------------------------------------------------------------
package enc_pkg;

   // Encoder control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ENC  = 2'd1,
      TAIL = 2'd2,
      DONE = 2'd3
   } enc_state_t;

   // Default code: K=3, (7,5) octal generators, 8-bit frames.
   localparam int          ENC_K        = 3;
   localparam logic [2:0]  ENC_G0       = 3'b111;
   localparam logic [2:0]  ENC_G1       = 3'b101;
   localparam int          ENC_DATA_W   = 8;

   // Trellis state width (shift register length) and coded bits per input bit.
   localparam int          ENC_STATE_W  = ENC_K - 1;
   localparam int          ENC_OUT_BITS = 2;

endpackage : enc_pkg

// File: rtl/conv_parity.sv
// -----------------------------------------------------------------------------
// conv_parity
// Combinational parity of one generator polynomial over the encoder taps.
//
// Ports:
//   taps    in  K   {shreg, u}; bit 0 is the current input, bit i the input
//                   delayed i beats
//   poly    in  K   generator polynomial, same bit convention as taps
//   parity  out 1   XOR of (taps & poly)
// -----------------------------------------------------------------------------
module conv_parity #(
   parameter int K = 3
) (
   input  logic [K-1:0] taps,
   input  logic [K-1:0] poly,
   output logic         parity
);

   assign parity = ^(taps & poly);

endmodule : conv_parity

// File: rtl/conv_encoder.sv
// -----------------------------------------------------------------------------
// conv_encoder
// Rate-1/2 feed-forward convolutional encoder. Accepts one DATA_W-bit frame
// over a valid/ready handshake, then emits one 2-bit symbol per output
// handshake, frame LSB first. Every frame starts from trellis state 0.
//
// Build option:
//   ENC_TAIL_EN  when defined, K-1 zero tail symbols follow the data so the
//                trellis ends in state 0 (where the decoder's traceback
//                starts). When undefined the frame is DATA_W symbols.
//
// Ports:
//   clk      in   1       clock, rising edge
//   rst      in   1       asynchronous, active-low reset
//   i_valid  in   1       frame valid
//   i_data   in   DATA_W  frame bits, bit 0 encoded first
//   o_ready  out  1       encoder can take a frame (IDLE only)
//   o_valid  out  1       o_sym holds a valid symbol
//   i_ready  in   1       downstream accepts o_sym
//   o_sym    out  2       {c1,c0}; c1 from G0, c0 from G1; zero when !o_valid
//   o_last   out  1       o_sym is the final symbol of the frame
//   o_done   out  1       one-cycle pulse after the final symbol handshake
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Input side: i_valid/o_ready. Output side: o_valid/i_ready. While
// o_valid is high and i_ready low, o_sym/o_last and all state hold, so no
// symbol is dropped or repeated. o_valid never depends on i_ready.
// -----------------------------------------------------------------------------
module conv_encoder
   import enc_pkg::*;
#(
   parameter int           K      = ENC_K,
   parameter logic [K-1:0] G0     = K'(ENC_G0),
   parameter logic [K-1:0] G1     = K'(ENC_G1),
   parameter int           DATA_W = ENC_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [1:0]        o_sym,
   output logic              o_last,
   output logic              o_done
);

`ifdef ENC_TAIL_EN
   localparam logic TAIL_EN = 1'b1;
`else
   localparam logic TAIL_EN = 1'b0;
`endif

   localparam int IDX_W  = $clog2(DATA_W);
   localparam int TCNT_W = $clog2(K);

   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(K - 2);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   enc_state_t         state, state_nxt;
   logic [DATA_W-1:0]  data_q;
   logic [K-2:0]       shreg;    // bit 0 = newest input (tap 1)
   logic [IDX_W-1:0]   idx;
   logic [TCNT_W-1:0]  tcnt;

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------
   logic         u;
   logic [K-1:0] taps;
   logic         c1, c0;
   logic         hs;
   logic         idx_at_last;
   logic         tcnt_at_last;

   // Current input bit: data bit during ENC, forced zero in TAIL (and idle).
   assign u    = (state == ENC) ? data_q[idx] : 1'b0;
   assign taps = {shreg, u};

   conv_parity #(.K(K)) u_parity_c1 (
      .taps   (taps),
      .poly   (G0),
      .parity (c1)
   );

   conv_parity #(.K(K)) u_parity_c0 (
      .taps   (taps),
      .poly   (G1),
      .parity (c0)
   );

   assign idx_at_last  = (idx == IDX_LAST);
   assign tcnt_at_last = (tcnt == TCNT_LAST);

   // ---------------------------------------------------------------------------
   // Outputs and next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      o_ready   = 1'b0;
      o_valid   = 1'b0;
      o_last    = 1'b0;
      o_done    = 1'b0;
      o_sym     = 2'b00;

      case (state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               state_nxt = ENC;
            end
         end

         ENC: begin
            o_valid = 1'b1;
            o_sym   = {c1, c0};
            // Without a tail the last data beat ends the frame.
            o_last  = idx_at_last && !TAIL_EN;
            if (i_ready && idx_at_last) begin
               state_nxt = TAIL_EN ? TAIL : DONE;
            end
         end

         TAIL: begin
            o_valid = 1'b1;
            o_sym   = {c1, c0};
            o_last  = tcnt_at_last;
            if (i_ready && tcnt_at_last) begin
               state_nxt = DONE;
            end
         end

         DONE: begin
            o_done    = 1'b1;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign hs = o_valid && i_ready;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         data_q <= '0;
         shreg  <= '0;
         idx    <= '0;
         tcnt   <= '0;
      end else begin
         state <= state_nxt;

         case (state)
            IDLE: begin
               if (i_valid) begin
                  data_q <= i_data;
                  shreg  <= '0;   // every frame starts in trellis state 0
                  idx    <= '0;
                  tcnt   <= '0;
               end
            end

            ENC: begin
               if (hs) begin
                  // Shift the current bit in as tap 1; oldest tap falls off.
                  shreg <= taps[K-2:0];
                  if (!idx_at_last) begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end

            TAIL: begin
               if (hs) begin
                  shreg <= taps[K-2:0];
                  if (!tcnt_at_last) begin
                     tcnt <= tcnt + TCNT_W'(1);
                  end
               end
            end

            default: begin
            end
         endcase
      end
   end

endmodule : conv_encoder

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2 feed-forward convolutional encoder at the transmit end of the Viterbi link. It accepts one DATA_W-bit frame over a valid/ready handshake. It then emits one 2-bit coded symbol per accepted output beat, LSB of the frame first. Optional zero tail bits terminate the trellis in state 0, which is the state the decoder's traceback starts from.

## Interface
- K, 3: constraint length; shift register holds K-1 bits; legal 2..7.
- G0, 3'b111: generator polynomial for symbol bit 1; bit 0 taps the current input, bit i taps the input delayed i beats.
- G1, 3'b101: generator polynomial for symbol bit 0; same tap convention.
- DATA_W, 8: information bits per frame; legal 2..64.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- i_valid  input  1  frame valid.
- i_data  input  DATA_W  frame bits; bit 0 is encoded first.
- o_ready  output  1  encoder can accept a frame; high only in IDLE.
- o_valid  output  1  o_sym holds a valid symbol.
- i_ready  input  1  downstream accepts o_sym.
- o_sym  output  2  coded symbol {c1,c0}; c1 = XOR(G0 & taps), c0 = XOR(G1 & taps), taps = {shreg, u}.
- o_last  output  1  o_sym is the final symbol of the frame.
- o_done  output  1  one-cycle pulse after the final symbol handshake.

## Operation
- State machine: IDLE -> ENC -> (TAIL) -> DONE -> IDLE.
- IDLE:
  - o_ready=1.
  - On i_valid && o_ready: latch i_data into data_q; clear shreg (K-1 bits) to 0; idx<=0; go to ENC.
- ENC:
  - u = data_q[idx]; o_valid=1; o_sym is combinational from registered shreg and u.
  - On handshake (o_valid && i_ready): shreg <= {shreg[K-3:0], u}, with newest bit at the LSB side as tap 1; idx <= idx+1.
  - On the handshake with idx==DATA_W-1: go to TAIL if tail is enabled, else DONE.
- TAIL:
  - u=0; o_valid=1; tcnt counts K-1 handshakes.
  - On the last tail handshake: go to DONE. shreg is then all-zero, i.e. trellis state 0.
- DONE: o_done=1 for exactly one cycle, o_valid=0; then IDLE.
- Backpressure: with i_ready=0, o_sym, o_last, idx, tcnt and shreg hold stable; no symbol is dropped or repeated.
- o_last=1 while o_valid and the current beat is the final one: idx==DATA_W-1 with tail off, or tcnt==K-2 with tail on.
- i_valid is ignored outside IDLE; a frame is never queued.
- Counter widths: idx is $clog2(DATA_W) bits, tcnt is $clog2(K) bits; neither wraps within a frame.
- Reset mid-frame: the frame is abandoned and outputs return to reset values immediately.

## Timing
- Reset values: o_ready=1, o_valid=0, o_sym=2'b00, o_last=0, o_done=0. State=IDLE; shreg, data_q, idx, tcnt all 0.
- Frame accepted at edge N -> first symbol valid in cycle N+1.
- With i_ready held high: symbols in cycles N+1 .. N+DATA_W+T, where T=K-1 with tail on and 0 with tail off.
  - o_done in cycle N+DATA_W+T+1.
  - o_ready back in cycle N+DATA_W+T+2.
- Throughput: one frame per DATA_W+T+2 cycles.
- o_sym is zero whenever o_valid=0.

## Configuration
- ENC_TAIL_EN defined: K-1 zero tail symbols are appended, the frame totals DATA_W+K-1 symbols, and the final state is 0.
- ENC_TAIL_EN undefined: TAIL is never entered and the frame totals DATA_W symbols. shreg is still cleared at the next frame accept, so every frame starts in state 0.

## Structure
- Shared package enc_pkg holds:
  - enc_state_t enum {IDLE, ENC, TAIL, DONE};
  - default K, G0, G1, DATA_W constants, shared with the decoder's state width and output bit count.
- Sub-module conv_parity: combinational; inputs taps and polynomial; output one parity bit. Instantiated twice, for c1 and c0.

## Test plan
- Reset: assert rst low mid-ENC -> o_valid=0, o_ready=1, o_sym=00 immediately; the next frame encodes from state 0.
- Tail on, DATA_W=4, K=3, G0=111, G1=101, i_data=4'b1011, i_ready=1:
  - symbols 11,01,01,00,10,11;
  - o_last on the 6th symbol;
  - o_done in the following cycle.
- Same frame with ENC_TAIL_EN undefined -> symbols 11,01,01,00; o_last on the 4th symbol.
- Backpressure: drop i_ready for 3 cycles at the 2nd symbol -> o_sym stays 01 and stable; sequence otherwise identical.
- i_valid held high throughout -> exactly one frame per DATA_W+T+2 cycles; i_data changes during ENC do not affect symbols.
- Loopback: random 1000 frames into conv_encoder -> Viterbi decoder with tail on -> decoded data equals i_data for every frame.
